// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between the ALU writeback (A)
//   and the memory-load writeback (B). When both requesters want the port in the
//   same cycle, round-robin arbitration picks one of them. The write port outputs
//   are registered and go straight to the RegisterFile. The same registered write
//   is exposed on pend_* so that decode can spot read-after-write hazards.
module regfile_write_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int DROP_R0 = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_rd,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        return v + CNT_W'(1);
    endfunction

    // A write that reaches r0 completes its handshake. It still drives write_enable
    // low when r0 is hard-wired.
    function automatic logic write_kept(input logic [ADDR_W-1:0] r);
        return !((DROP_R0 != 0) && (r == '0));
    endfunction

    logic              last_grant_q;
    logic              a_ready_p0;
    logic              b_ready_p0;
    logic              xfer_p0;
    logic              conflict_p0;
    logic [ADDR_W-1:0] sel_rd_p0;
    logic [DATA_W-1:0] sel_data_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] rd_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CNT_W-1:0]  conflict_q;

    // ---- Stage p0: combinational grant and write-port mux ----

    // Round-robin grant. During reset no grant is issued, so a pending request
    // is not consumed.
    always_comb begin
        a_ready_p0 = 1'b0;
        b_ready_p0 = 1'b0;
        if (!reset) begin
            if (a_valid && b_valid) begin
                a_ready_p0 = (last_grant_q == GRANT_B);
                b_ready_p0 = (last_grant_q == GRANT_A);
            end else begin
                a_ready_p0 = a_valid;
                b_ready_p0 = b_valid;
            end
        end
    end

    // Select the winning requester's register index and data.
    always_comb begin
        xfer_p0     = a_ready_p0 | b_ready_p0;
        conflict_p0 = a_valid & b_valid;
        sel_rd_p0   = b_ready_p0 ? b_rd   : a_rd;
        sel_data_p0 = b_ready_p0 ? b_data : a_data;
    end

    // Remember who won the last transfer. After reset it points at B, so A
    // wins the first conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant_q <= GRANT_B;
        else if (xfer_p0)
            last_grant_q <= b_ready_p0 ? GRANT_B : GRANT_A;
    end

    // ---- Stage p1: registered write port ----

    // Register the granted write. rd and data hold their values when there is no
    // transfer. A dropped r0 write still updates rd and data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0 && write_kept(sel_rd_p0);
            if (xfer_p0) begin
                rd_p1   <= sel_rd_p0;
                data_p1 <= sel_data_p0;
            end
        end
    end

    // Count the cycles in which both requesters were valid. The count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            conflict_q <= '0;
        else if (conflict_p0)
            conflict_q <= sat_inc(conflict_q);
    end

    assign a_ready      = a_ready_p0;
    assign b_ready      = b_ready_p0;
    assign write_enable = vld_p1;
    assign rd           = rd_p1;
    assign write_data   = data_p1;
    assign pend_valid   = vld_p1;
    assign pend_rd      = rd_p1;
    assign conflict_cnt = conflict_q;

endmodule
